// File: rtl/seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_scan_decoder                                                           |
// | Follows a 4-digit multiplexed 7-segment scan and rebuilds the hex frame.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module seg_scan_decoder #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        segclk,
  input  logic        clr,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  score,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        sync_err,
  output logic        stale
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] c_TIMEOUT = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] WAIT_L  = 2'd0;
  localparam logic [1:0] WAIT_ML = 2'd1;
  localparam logic [1:0] WAIT_MR = 2'd2;
  localparam logic [1:0] WAIT_R  = 2'd3;

  localparam logic [3:0] c_AN_BLANK = 4'b1111;
  localparam logic [3:0] c_AN_L     = 4'b0111;
  localparam logic [3:0] c_AN_ML    = 4'b1011;
  localparam logic [3:0] c_AN_MR    = 4'b1101;
  localparam logic [3:0] c_AN_R     = 4'b1110;

  logic [1:0]    r_state;
  logic [3:0]    r_sh_l;
  logic [3:0]    r_sh_ml;
  logic [3:0]    r_sh_mr;
  logic          r_sh_err;
  logic [CW-1:0] r_cnt;

  logic [3:0]    w_nib;
  logic          w_bad;
  logic [3:0]    w_an_exp;
  logic          w_onehot;
  logic [1:0]    w_state_nxt;
  logic          w_cap;
  logic [1:0]    w_cap_slot;
  logic          w_err_nxt;
  logic          w_publish;
  logic          w_sync;
  logic [CW-1:0] w_cnt_nxt;

  // Active-low segment pattern back to a nibble; unknown patterns flag the digit.
  always_comb begin
    w_nib = 4'h0;
    w_bad = 1'b0;
    case (seg)
      7'b1000000: w_nib = 4'h0;
      7'b1111001: w_nib = 4'h1;
      7'b0100100: w_nib = 4'h2;
      7'b0110000: w_nib = 4'h3;
      7'b0011001: w_nib = 4'h4;
      7'b0010010: w_nib = 4'h5;
      7'b0000010: w_nib = 4'h6;
      7'b1111000: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0010000: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b0000011: w_nib = 4'hB;
      7'b1000110: w_nib = 4'hC;
      7'b0100001: w_nib = 4'hD;
      7'b0000110: w_nib = 4'hE;
      7'b0001110: w_nib = 4'hF;
      default:    w_bad = 1'b1;
    endcase
  end

  always_comb begin
    case (r_state)
      WAIT_L:  w_an_exp = c_AN_L;
      WAIT_ML: w_an_exp = c_AN_ML;
      WAIT_MR: w_an_exp = c_AN_MR;
      default: w_an_exp = c_AN_R;
    endcase
  end

  assign w_onehot = (an == c_AN_L) || (an == c_AN_ML) || (an == c_AN_MR) || (an == c_AN_R);

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_cap_slot  = r_state;
    w_err_nxt   = r_sh_err;
    w_publish   = 1'b0;
    w_sync      = 1'b0;
    if (an == c_AN_BLANK) begin
      w_state_nxt = r_state;
    end else if (an == w_an_exp) begin
      w_cap     = 1'b1;
      w_err_nxt = r_sh_err | w_bad;
      if (r_state == WAIT_R) begin
        w_publish   = 1'b1;
        w_err_nxt   = 1'b0;
        w_state_nxt = WAIT_L;
      end else begin
        w_state_nxt = r_state + 2'd1;
      end
    end else if (w_onehot) begin
      w_sync = 1'b1;
      // A stray left digit restarts the frame rather than being thrown away.
      if (an == c_AN_L) begin
        w_cap       = 1'b1;
        w_cap_slot  = WAIT_L;
        w_err_nxt   = w_bad;
        w_state_nxt = WAIT_ML;
      end else begin
        w_err_nxt   = 1'b0;
        w_state_nxt = WAIT_L;
      end
    end else begin
      w_sync      = 1'b1;
      w_err_nxt   = 1'b0;
      w_state_nxt = WAIT_L;
    end
  end

  always_comb begin
    if (w_publish)
      w_cnt_nxt = '0;
    else if (r_cnt == c_TIMEOUT)
      w_cnt_nxt = r_cnt;
    else
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      r_state     <= WAIT_L;
      r_sh_l      <= 4'h0;
      r_sh_ml     <= 4'h0;
      r_sh_mr     <= 4'h0;
      r_sh_err    <= 1'b0;
      r_cnt       <= '0;
      digits      <= 16'h0000;
      score       <= 4'h0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      sync_err    <= 1'b0;
      stale       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh_err    <= w_err_nxt;
      r_cnt       <= w_cnt_nxt;
      frame_valid <= w_publish;
      sync_err    <= w_sync;
      stale       <= (w_cnt_nxt == c_TIMEOUT);
      if (w_cap) begin
        case (w_cap_slot)
          WAIT_L:  r_sh_l  <= w_nib;
          WAIT_ML: r_sh_ml <= w_nib;
          WAIT_MR: r_sh_mr <= w_nib;
          default: ;
        endcase
      end
      if (w_publish) begin
        digits    <= {r_sh_l, r_sh_ml, r_sh_mr, w_nib};
        score     <= w_nib;
        frame_err <= r_sh_err | w_bad;
      end
    end
  end

endmodule
`default_nettype wire
